// File: rtl/alu_mc.sv
// alu_mc: multi-cycle accumulator ALU with valid/ready handshake.
// Single-cycle ops complete on the accepting edge; MUL/DIV iterate one bit per cycle.
module alu_mc #(
  parameter int WIDTH     = 8,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accumulator,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [7:0]       status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       status_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2,  OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4,  OP_ASL = 4'd5,  OP_LSR = 4'd6,  OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_CMP = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_DIV = 4'd13;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] reg_hi, reg_lo, reg_b;
  logic             is_div;
  logic [3:0]       st_keep;

  // single-cycle datapath signals
  logic [WIDTH-1:0] sc_res, sc_hi, bop, nz_val, dec_add, dec_sub;
  logic [WIDTH:0]   bsum, cmp_d;
  logic [4:0]       dsum, ddif;
  logic             dc, db, bin_v, sc_c, sc_v, upd_nz, sc_iter;
  logic [7:0]       sc_st;

  // iteration step signals
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [7:0]       fin_st;

  logic accept;

  assign in_ready = rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign sc_iter  = (MULDIV_EN != 0) &&
                    ((op == OP_MUL) || ((op == OP_DIV) && (operand_2 != '0)));

  // Single-cycle result and flags computed from the live request inputs
  always_comb begin
    bop    = (op == OP_SBC) ? ~operand_2 : operand_2;
    bsum   = {1'b0, accumulator} + {1'b0, bop} + {{WIDTH{1'b0}}, status[0]};
    bin_v  = (accumulator[WIDTH-1] == bop[WIDTH-1]) && (bsum[WIDTH-1] != accumulator[WIDTH-1]);
    cmp_d  = {1'b0, accumulator} + {1'b0, ~operand_2} + {{WIDTH{1'b0}}, 1'b1};
    // BCD digits ripple a carry (ADC) or borrow (SBC) from the low nibble upward
    dec_add = '0;
    dec_sub = '0;
    dc      = status[0];
    db      = ~status[0];
    dsum    = '0;
    ddif    = '0;
    for (int unsigned i = 0; i < WIDTH / 4; i++) begin
      dsum = {1'b0, accumulator[4*i +: 4]} + {1'b0, operand_2[4*i +: 4]} + {4'b0, dc};
      if (dsum > 5'd9) begin
        dsum = dsum + 5'd6;
        dc   = 1'b1;
      end else begin
        dc   = 1'b0;
      end
      dec_add[4*i +: 4] = dsum[3:0];
      ddif = {1'b0, accumulator[4*i +: 4]} - {1'b0, operand_2[4*i +: 4]} - {4'b0, db};
      if (ddif[4]) begin
        ddif = ddif - 5'd6;
        db   = 1'b1;
      end else begin
        db   = 1'b0;
      end
      dec_sub[4*i +: 4] = ddif[3:0];
    end

    sc_res = accumulator;
    sc_hi  = '0;
    sc_c   = status[0];
    sc_v   = status[6];
    upd_nz = 1'b1;
    nz_val = '0;
    case (op)
      OP_ADC, OP_SBC: begin
        sc_v = bin_v;
        if (status[3]) begin
          sc_res = (op == OP_ADC) ? dec_add : dec_sub;
          sc_c   = (op == OP_ADC) ? dc : ~db;
        end else begin
          sc_res = bsum[WIDTH-1:0];
          sc_c   = bsum[WIDTH];
        end
      end
      OP_AND: sc_res = accumulator & operand_2;
      OP_ORA: sc_res = accumulator | operand_2;
      OP_EOR: sc_res = accumulator ^ operand_2;
      OP_ASL: begin sc_res = {accumulator[WIDTH-2:0], 1'b0};      sc_c = accumulator[WIDTH-1]; end
      OP_LSR: begin sc_res = {1'b0, accumulator[WIDTH-1:1]};      sc_c = accumulator[0];       end
      OP_ROL: begin sc_res = {accumulator[WIDTH-2:0], status[0]}; sc_c = accumulator[WIDTH-1]; end
      OP_ROR: begin sc_res = {status[0], accumulator[WIDTH-1:1]}; sc_c = accumulator[0];       end
      OP_INC: sc_res = accumulator + WIDTH'(1);
      OP_DEC: sc_res = accumulator - WIDTH'(1);
      OP_CMP: sc_c = cmp_d[WIDTH];
      OP_DIV: begin
        if (MULDIV_EN != 0) begin
          sc_res = '1;
          sc_hi  = accumulator;
          sc_c   = 1'b0;
          sc_v   = 1'b1;
        end else begin
          upd_nz = 1'b0;
        end
      end
      default: upd_nz = 1'b0;
    endcase
    nz_val = (op == OP_CMP) ? cmp_d[WIDTH-1:0] : sc_res;
    sc_st  = {upd_nz ? nz_val[WIDTH-1] : status[7], sc_v, status[5:2],
              upd_nz ? (nz_val == '0) : status[1], sc_c};
  end

  // One shift-add or restoring-divide step on the working registers
  always_comb begin
    mul_sum  = {1'b0, reg_hi} + (reg_lo[0] ? {1'b0, reg_b} : '0);
    div_sh   = {reg_hi, reg_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, reg_b};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {reg_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {reg_lo[WIDTH-2:0], 1'b0};
      end
      fin_st = {step_lo[WIDTH-1], 1'b0, st_keep, (step_lo == '0), 1'b0};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], reg_lo[WIDTH-1:1]};
      fin_st  = {step_hi[WIDTH-1], 1'b0, st_keep, ({step_hi, step_lo} == '0), (step_hi != '0)};
    end
  end

  // Control FSM with registered outputs and iterative working registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      status_out <= '0;
      reg_hi     <= '0;
      reg_lo     <= '0;
      reg_b      <= '0;
      is_div     <= 1'b0;
      st_keep    <= '0;
    end else if (state == ITER) begin
      reg_hi <= step_hi;
      reg_lo <= step_lo;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state      <= DONE;
        busy       <= 1'b0;
        out_valid  <= 1'b1;
        result     <= step_lo;
        result_hi  <= step_hi;
        status_out <= fin_st;
      end
    end else if (accept) begin
      if (sc_iter) begin
        state     <= ITER;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        cnt       <= CW'(WIDTH);
        reg_hi    <= '0;
        reg_lo    <= accumulator;
        reg_b     <= operand_2;
        is_div    <= (op == OP_DIV);
        st_keep   <= status[5:2];
      end else begin
        state      <= DONE;
        out_valid  <= 1'b1;
        result     <= sc_res;
        result_hi  <= sc_hi;
        status_out <= sc_st;
      end
    end else if ((state == DONE) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven vectors with a scoreboard queue, plus handshake/reset sequences.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] op;
  logic [7:0] accumulator, operand_2, status, result, result_hi, status_out;

  alu_mc #(.WIDTH(8), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .accumulator(accumulator), .operand_2(operand_2), .status(status),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .status_out(status_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, st, er, eh, es;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] er, eh, es;
    int         lat;
    int         acc;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (item %0d): got %h expected %h", nm, id, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] st, input logic [7:0] er, input logic [7:0] eh,
                              input logic [7:0] es, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.st = st; v.er = er; v.eh = eh; v.es = es; v.lat = lat;
    return v;
  endfunction

  // Drive one request (called right after a falling edge) and push its expectation on acceptance
  task automatic issue(input vec_t v);
    int   n;
    exp_t e;
    op = v.op; accumulator = v.a; operand_2 = v.b; status = v.st; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout (op %0d): in_ready stayed 0, expected 1", v.op);
      @(negedge clk);
      in_valid = 1'b0;
    end else begin
      e.er = v.er; e.eh = v.eh; e.es = v.es; e.lat = v.lat; e.acc = cyc + 1; e.id = next_id;
      next_id++;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard: compare each result on the cycle the consumer takes it
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got %h with empty scoreboard, expected none", result);
      end else begin
        e = sb.pop_front();
        chk("result", e.id, {8'h0, result}, {8'h0, e.er});
        chk("result_hi", e.id, {8'h0, result_hi}, {8'h0, e.eh});
        chk("status_out", e.id, {8'h0, status_out}, {8'h0, e.es});
        if (e.lat >= 0) chk("latency", e.id, 16'(cyc - e.acc), 16'(e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; accumulator = '0; operand_2 = '0; status = '0;

    vecs.push_back(mk(4'd0,  8'h42, 8'h1E, 8'h00, 8'h60, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd1,  8'h42, 8'h1E, 8'h01, 8'h24, 8'h00, 8'h01, 0));
    vecs.push_back(mk(4'd2,  8'h42, 8'h1E, 8'h00, 8'h02, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd3,  8'h42, 8'h1E, 8'h00, 8'h5E, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd4,  8'h42, 8'h1E, 8'h00, 8'h5C, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd5,  8'h42, 8'h1E, 8'h00, 8'h84, 8'h00, 8'h80, 0));
    vecs.push_back(mk(4'd6,  8'h42, 8'h1E, 8'h00, 8'h21, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd7,  8'h42, 8'h1E, 8'h01, 8'h85, 8'h00, 8'h80, 0));
    vecs.push_back(mk(4'd8,  8'h42, 8'h1E, 8'h01, 8'hA1, 8'h00, 8'h80, 0));
    vecs.push_back(mk(4'd9,  8'h42, 8'h1E, 8'h00, 8'h43, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd10, 8'h42, 8'h1E, 8'h00, 8'h41, 8'h00, 8'h00, 0));
    vecs.push_back(mk(4'd11, 8'h42, 8'h1E, 8'h00, 8'h42, 8'h00, 8'h01, 0));
    vecs.push_back(mk(4'd11, 8'h10, 8'h20, 8'h00, 8'h10, 8'h00, 8'h80, 0));
    vecs.push_back(mk(4'd0,  8'h7F, 8'h01, 8'h00, 8'h80, 8'h00, 8'hC0, 0));
    vecs.push_back(mk(4'd0,  8'hFF, 8'h01, 8'h34, 8'h00, 8'h00, 8'h37, 0));
    vecs.push_back(mk(4'd10, 8'h01, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h43, 0));
    vecs.push_back(mk(4'd0,  8'h45, 8'h38, 8'h08, 8'h83, 8'h00, 8'h88, 0));
    vecs.push_back(mk(4'd0,  8'h99, 8'h01, 8'h08, 8'h00, 8'h00, 8'h0B, 0));
    vecs.push_back(mk(4'd1,  8'h40, 8'h01, 8'h09, 8'h39, 8'h00, 8'h09, 0));
    vecs.push_back(mk(4'd12, 8'h42, 8'h1E, 8'h00, 8'hBC, 8'h07, 8'h01, 8));
    vecs.push_back(mk(4'd13, 8'h42, 8'h1E, 8'hFF, 8'h02, 8'h06, 8'h3C, 8));
    vecs.push_back(mk(4'd13, 8'h42, 8'h00, 8'h00, 8'hFF, 8'h42, 8'hC0, 0));
    vecs.push_back(mk(4'd12, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h81, 8));
    vecs.push_back(mk(4'd12, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8));
    vecs.push_back(mk(4'd13, 8'h05, 8'h07, 8'h00, 8'h00, 8'h05, 8'h02, 8));
    vecs.push_back(mk(4'd14, 8'h42, 8'h1E, 8'h5A, 8'h42, 8'h00, 8'h5A, 0));
    vecs.push_back(mk(4'd15, 8'h42, 8'h1E, 8'hA5, 8'h42, 8'h00, 8'hA5, 0));

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", -1, {15'h0, out_valid}, 16'h0);
    chk("rst_busy", -1, {15'h0, busy}, 16'h0);
    chk("rst_result", -1, {8'h0, result}, 16'h0);
    chk("rst_result_hi", -1, {8'h0, result_hi}, 16'h0);
    chk("rst_status_out", -1, {8'h0, status_out}, 16'h0);
    chk("rst_in_ready", -1, {15'h0, in_ready}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", -1, {15'h0, in_ready}, 16'h1);

    // Table vectors, back-to-back where the DUT allows
    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // MUL busy window
    issue(mk(4'd12, 8'h42, 8'h1E, 8'h00, 8'hBC, 8'h07, 8'h01, 8));
    #1;
    bcnt = 0;
    while (busy && bcnt < 20) begin
      bcnt++;
      @(negedge clk); #1;
    end
    chk("busy_cycles", -1, 16'(bcnt), 16'd8);
    drain();

    // Backpressure: result held while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    issue(mk(4'd0, 8'h42, 8'h1E, 8'h00, 8'h60, 8'h00, 8'h00, -1));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_out_valid", k, {15'h0, out_valid}, 16'h1);
      chk("bp_result", k, {8'h0, result}, 16'h60);
      chk("bp_status_out", k, {8'h0, status_out}, 16'h00);
      chk("bp_in_ready", k, {15'h0, in_ready}, 16'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(mk(4'd3, 8'h42, 8'h1E, 8'h00, 8'h5E, 8'h00, 8'h00, 0));
    drain();

    // Reset three cycles into a MUL
    issue(mk(4'd12, 8'h42, 8'h1E, 8'h00, 8'hBC, 8'h07, 8'h01, 8));
    repeat (3) @(negedge clk);
    #1;
    chk("mid_busy", -1, {15'h0, busy}, 16'h1);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("abort_out_valid", -1, {15'h0, out_valid}, 16'h0);
    chk("abort_busy", -1, {15'h0, busy}, 16'h0);
    chk("abort_result", -1, {8'h0, result}, 16'h0);
    chk("abort_result_hi", -1, {8'h0, result_hi}, 16'h0);
    chk("abort_status_out", -1, {8'h0, status_out}, 16'h0);
    chk("abort_in_ready", -1, {15'h0, in_ready}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rel_in_ready", -1, {15'h0, in_ready}, 16'h1);
    issue(mk(4'd0, 8'h45, 8'h38, 8'h00, 8'h7D, 8'h00, 8'h00, 0));
    drain();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
